// File: rtl/rename_pkg.sv
// Shared sizing defaults and types for the integer rename map and its checkpoint store.
package rename_pkg;

    localparam int NUM_ARF    = 32;
    localparam int NUM_PRF    = 64;
    localparam int NUM_CKPT   = 4;
    localparam int ARF_IDX_W  = $clog2(NUM_ARF);
    localparam int PRF_IDX_W  = $clog2(NUM_PRF);
    localparam int CKPT_IDX_W = $clog2(NUM_CKPT);

    typedef logic [ARF_IDX_W-1:0]  arf_idx_t;
    typedef logic [PRF_IDX_W-1:0]  prf_idx_t;
    typedef logic [CKPT_IDX_W-1:0] ckpt_idx_t;
    typedef prf_idx_t [NUM_ARF-1:0] rename_map_t;

endpackage

// File: rtl/rename_ckpt_buffer.sv
// Circular store of rename-map snapshots taken at branches, with head/tail/count tracking.
// Write at tail on a firing branch, combinational read for recovery, release frees the oldest.
module rename_ckpt_buffer
    import rename_pkg::*;
#(
    parameter int ARF_SIZE = NUM_ARF,
    parameter int PRF_IDX  = PRF_IDX_W,
    parameter int CKPT_NUM = NUM_CKPT,
    localparam int CKPT_IDX = $clog2(CKPT_NUM)
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               wr_en,
    input  logic [ARF_SIZE-1:0][PRF_IDX-1:0]   wr_map,
    input  logic                               ckpt_release,
    input  logic                               recover,
    input  logic [CKPT_IDX-1:0]                recover_ckpt,
    output logic [ARF_SIZE-1:0][PRF_IDX-1:0]   rd_map,
    output logic [CKPT_IDX-1:0]                tail,
    output logic [CKPT_IDX:0]                  count
);

    localparam logic [CKPT_IDX:0]   CKPT_FULL = (CKPT_IDX+1)'(CKPT_NUM);
    localparam logic [CKPT_IDX:0]   CNT_ONE   = (CKPT_IDX+1)'(1);
    localparam logic [CKPT_IDX-1:0] IDX_ONE   = CKPT_IDX'(1);

    logic [ARF_SIZE-1:0][PRF_IDX-1:0] snap [CKPT_NUM];
    logic [CKPT_IDX-1:0] head;
    logic [CKPT_IDX-1:0] head_nxt;
    logic [CKPT_IDX-1:0] tail_nxt;
    logic [CKPT_IDX-1:0] span;
    logic [CKPT_IDX:0]   count_nxt;

    always_comb begin
        head_nxt  = ckpt_release ? head + IDX_ONE : head;
        tail_nxt  = tail;
        count_nxt = count;
        span      = '0;
        if (recover) begin
            // The recovered checkpoint stays live, so a zero span means the ring is full.
            tail_nxt  = recover_ckpt + IDX_ONE;
            span      = tail_nxt - head_nxt;
            count_nxt = (span == '0) ? CKPT_FULL : {1'b0, span};
        end else begin
            if (wr_en) begin
                tail_nxt  = tail + IDX_ONE;
                count_nxt = count + CNT_ONE;
            end
            if (ckpt_release) begin
                count_nxt = count_nxt - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head_nxt;
            tail  <= tail_nxt;
            count <= count_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            snap[tail] <= wr_map;
        end
    end

    assign rd_map = snap[recover_ckpt];

    always @(posedge clock) begin
        if (reset_n) begin
            assert (!(ckpt_release && count == '0))
                else $error("checkpoint release with no live checkpoint");
            assert (!(ckpt_release && recover && recover_ckpt == head))
                else $error("recovery targets the checkpoint being released");
        end
    end

endmodule

// File: rtl/rename_map_int.sv
// Integer register alias table: renames a group of sources/destinations, one-cycle registered output.
// Stall freezes map and outputs; a full checkpoint ring blocks branch groups; recover wins over fire.
module rename_map_int
    import rename_pkg::*;
#(
    parameter int RENAME_WIDTH = 2,
    parameter int ARF_SIZE     = NUM_ARF,
    parameter int PRF_SIZE     = NUM_PRF,
    parameter int CKPT_NUM     = NUM_CKPT,
    localparam int ARF_IDX  = $clog2(ARF_SIZE),
    localparam int PRF_IDX  = $clog2(PRF_SIZE),
    localparam int CKPT_IDX = $clog2(CKPT_NUM)
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic                                   stall,
    input  logic [RENAME_WIDTH-1:0]                in_valid,
    input  logic [RENAME_WIDTH-1:0]                in_rd_valid,
    input  logic [RENAME_WIDTH-1:0][ARF_IDX-1:0]   in_rs1,
    input  logic [RENAME_WIDTH-1:0][ARF_IDX-1:0]   in_rs2,
    input  logic [RENAME_WIDTH-1:0][ARF_IDX-1:0]   in_rd,
    input  logic [RENAME_WIDTH-1:0]                in_branch,
    output logic [RENAME_WIDTH-1:0]                prf_req,
    input  logic [RENAME_WIDTH-1:0][PRF_IDX-1:0]   prf_alloc,
    input  logic                                   allocatable,
    output logic                                   rename_ready,
    output logic [RENAME_WIDTH-1:0]                out_valid,
    output logic [RENAME_WIDTH-1:0][PRF_IDX-1:0]   out_prs1,
    output logic [RENAME_WIDTH-1:0][PRF_IDX-1:0]   out_prs2,
    output logic [RENAME_WIDTH-1:0][PRF_IDX-1:0]   out_prd,
    output logic [RENAME_WIDTH-1:0][PRF_IDX-1:0]   out_prd_old,
    output logic [RENAME_WIDTH-1:0][CKPT_IDX-1:0]  out_ckpt,
    input  logic                                   recover,
    input  logic [CKPT_IDX-1:0]                    recover_ckpt,
    input  logic                                   ckpt_release
);

    typedef logic [ARF_SIZE-1:0][PRF_IDX-1:0] map_t;

    localparam logic [CKPT_IDX:0]   CKPT_FULL = (CKPT_IDX+1)'(CKPT_NUM);
    localparam logic [CKPT_IDX-1:0] IDX_ONE   = CKPT_IDX'(1);

    map_t map_q;
    map_t ckpt_map;
    map_t snap_map;
    map_t stage [RENAME_WIDTH+1];

    logic [CKPT_IDX-1:0] tail;
    logic [CKPT_IDX:0]   count;
    logic [RENAME_WIDTH-1:0] need;
    logic any_branch;
    logic ckpt_ok;
    logic fire;
    logic ckpt_wr;
    logic branch_seen;

    logic [RENAME_WIDTH-1:0][PRF_IDX-1:0]  prs1_c;
    logic [RENAME_WIDTH-1:0][PRF_IDX-1:0]  prs2_c;
    logic [RENAME_WIDTH-1:0][PRF_IDX-1:0]  prd_c;
    logic [RENAME_WIDTH-1:0][PRF_IDX-1:0]  prd_old_c;
    logic [RENAME_WIDTH-1:0][CKPT_IDX-1:0] ckpt_c;

    always_comb begin
        need       = '0;
        any_branch = 1'b0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            need[i]    = in_valid[i] & in_rd_valid[i] & (in_rd[i] != '0);
            any_branch = any_branch | (in_valid[i] & in_branch[i]);
        end
        ckpt_ok = !any_branch || (count < CKPT_FULL);
        prf_req = need & {RENAME_WIDTH{ckpt_ok & !recover}};
        fire    = (|in_valid) & allocatable & ckpt_ok & !stall & !recover;
    end

    assign rename_ready = fire;
    assign ckpt_wr      = fire & any_branch;

    // stage[i] is the map as seen by slot i: older slots' writes are already folded in,
    // which gives the intra-group bypass and the per-branch snapshot for free.
    always_comb begin
        stage[0]    = map_q;
        snap_map    = map_q;
        branch_seen = 1'b0;
        prs1_c      = '0;
        prs2_c      = '0;
        prd_c       = '0;
        prd_old_c   = '0;
        ckpt_c      = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            prs1_c[i]    = (in_rs1[i] == '0) ? '0 : stage[i][in_rs1[i]];
            prs2_c[i]    = (in_rs2[i] == '0) ? '0 : stage[i][in_rs2[i]];
            prd_old_c[i] = (in_rd[i] == '0) ? '0 : stage[i][in_rd[i]];
            prd_c[i]     = need[i] ? prf_alloc[i] : '0;
            stage[i+1]   = stage[i];
            if (need[i]) begin
                stage[i+1][in_rd[i]] = prf_alloc[i];
            end
            if (in_valid[i] && in_branch[i]) begin
                snap_map    = stage[i+1];
                branch_seen = 1'b1;
            end
            ckpt_c[i] = branch_seen ? tail : tail - IDX_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            map_q <= '0;
        end else if (recover) begin
            map_q <= ckpt_map;
        end else if (fire) begin
            map_q <= stage[RENAME_WIDTH];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= '0;
            out_prs1    <= '0;
            out_prs2    <= '0;
            out_prd     <= '0;
            out_prd_old <= '0;
            out_ckpt    <= '0;
        end else if (recover) begin
            out_valid <= '0;
        end else if (!stall) begin
            out_valid <= fire ? in_valid : '0;
            if (fire) begin
                out_prs1    <= prs1_c;
                out_prs2    <= prs2_c;
                out_prd     <= prd_c;
                out_prd_old <= prd_old_c;
                out_ckpt    <= ckpt_c;
            end
        end
    end

    rename_ckpt_buffer #(
        .ARF_SIZE (ARF_SIZE),
        .PRF_IDX  (PRF_IDX),
        .CKPT_NUM (CKPT_NUM)
    ) u_ckpt (
        .clock        (clock),
        .reset_n      (reset_n),
        .wr_en        (ckpt_wr),
        .wr_map       (snap_map),
        .ckpt_release (ckpt_release),
        .recover      (recover),
        .recover_ckpt (recover_ckpt),
        .rd_map       (ckpt_map),
        .tail         (tail),
        .count        (count)
    );

endmodule

// File: tb/tb_rename_map_int.sv
// Directed bench for rename_map_int; the map is observed through probe groups that read sources.
module tb_rename_map_int;

    logic            clock;
    logic            reset_n;
    logic            stall;
    logic [1:0]      in_valid;
    logic [1:0]      in_rd_valid;
    logic [1:0][4:0] in_rs1;
    logic [1:0][4:0] in_rs2;
    logic [1:0][4:0] in_rd;
    logic [1:0]      in_branch;
    logic [1:0]      prf_req;
    logic [1:0][5:0] prf_alloc;
    logic            allocatable;
    logic            rename_ready;
    logic [1:0]      out_valid;
    logic [1:0][5:0] out_prs1;
    logic [1:0][5:0] out_prs2;
    logic [1:0][5:0] out_prd;
    logic [1:0][5:0] out_prd_old;
    logic [1:0][1:0] out_ckpt;
    logic            recover;
    logic [1:0]      recover_ckpt;
    logic            ckpt_release;

    int pass_cnt = 0;
    int total_cnt = 0;

    rename_map_int dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .stall        (stall),
        .in_valid     (in_valid),
        .in_rd_valid  (in_rd_valid),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_rd        (in_rd),
        .in_branch    (in_branch),
        .prf_req      (prf_req),
        .prf_alloc    (prf_alloc),
        .allocatable  (allocatable),
        .rename_ready (rename_ready),
        .out_valid    (out_valid),
        .out_prs1     (out_prs1),
        .out_prs2     (out_prs2),
        .out_prd      (out_prd),
        .out_prd_old  (out_prd_old),
        .out_ckpt     (out_ckpt),
        .recover      (recover),
        .recover_ckpt (recover_ckpt),
        .ckpt_release (ckpt_release)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic clear_in();
        in_valid     = '0;
        in_rd_valid  = '0;
        in_rs1       = '0;
        in_rs2       = '0;
        in_rd        = '0;
        in_branch    = '0;
        prf_alloc    = '0;
        allocatable  = 1'b1;
        stall        = 1'b0;
        recover      = 1'b0;
        recover_ckpt = '0;
        ckpt_release = 1'b0;
    endtask

    task automatic slot(input int i, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic rdv, input logic br,
                        input logic [5:0] alloc);
        in_valid[i]    = 1'b1;
        in_rs1[i]      = rs1;
        in_rs2[i]      = rs2;
        in_rd[i]       = rd;
        in_rd_valid[i] = rdv;
        in_branch[i]   = br;
        prf_alloc[i]   = alloc;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // A non-writing group that reads map[a] into out_prs1[0] and map[b] into out_prs2[0].
    task automatic probe(input logic [4:0] a, input logic [4:0] b);
        clear_in();
        slot(0, a, b, 5'd0, 1'b0, 1'b0, 6'd0);
        tick();
        clear_in();
    endtask

    task automatic test_reset();
        clear_in();
        reset_n = 1'b0;
        #2;
        total_cnt++; if (out_valid !== 2'b00) $display("FAIL reset_out_valid got %b want 00", out_valid); else pass_cnt++;
        total_cnt++; if (out_prd !== '0) $display("FAIL reset_out_prd got %h want 0", out_prd); else pass_cnt++;
        total_cnt++; if (out_ckpt !== '0) $display("FAIL reset_out_ckpt got %h want 0", out_ckpt); else pass_cnt++;
        total_cnt++; if (prf_req !== 2'b00) $display("FAIL reset_prf_req got %b want 00", prf_req); else pass_cnt++;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_one_slot();
        clear_in();
        slot(0, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 6'd7);
        #1;
        total_cnt++; if (prf_req !== 2'b01) $display("FAIL one_req got %b want 01", prf_req); else pass_cnt++;
        total_cnt++; if (rename_ready !== 1'b1) $display("FAIL one_ready got %b want 1", rename_ready); else pass_cnt++;
        tick();
        clear_in();
        total_cnt++; if (out_valid !== 2'b01) $display("FAIL one_valid got %b want 01", out_valid); else pass_cnt++;
        total_cnt++; if (out_prs1[0] !== 6'd0) $display("FAIL one_prs1 got %0d want 0", out_prs1[0]); else pass_cnt++;
        total_cnt++; if (out_prs2[0] !== 6'd0) $display("FAIL one_prs2 got %0d want 0", out_prs2[0]); else pass_cnt++;
        total_cnt++; if (out_prd[0] !== 6'd7) $display("FAIL one_prd got %0d want 7", out_prd[0]); else pass_cnt++;
        total_cnt++; if (out_prd_old[0] !== 6'd0) $display("FAIL one_prd_old got %0d want 0", out_prd_old[0]); else pass_cnt++;
        total_cnt++; if (out_ckpt[0] !== 2'd3) $display("FAIL one_ckpt got %0d want 3", out_ckpt[0]); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 2'b00) $display("FAIL idle_valid got %b want 00", out_valid); else pass_cnt++;
        probe(5'd5, 5'd1);
        total_cnt++; if (out_prs1[0] !== 6'd7) $display("FAIL one_map5 got %0d want 7", out_prs1[0]); else pass_cnt++;
    endtask

    task automatic test_bypass();
        clear_in();
        slot(0, 5'd5, 5'd0, 5'd3, 1'b1, 1'b0, 6'd9);
        slot(1, 5'd3, 5'd5, 5'd3, 1'b1, 1'b0, 6'd10);
        #1;
        total_cnt++; if (prf_req !== 2'b11) $display("FAIL byp_req got %b want 11", prf_req); else pass_cnt++;
        tick();
        clear_in();
        total_cnt++; if (out_prs1[0] !== 6'd7) $display("FAIL byp_s0_prs1 got %0d want 7", out_prs1[0]); else pass_cnt++;
        total_cnt++; if (out_prd_old[0] !== 6'd0) $display("FAIL byp_s0_old got %0d want 0", out_prd_old[0]); else pass_cnt++;
        total_cnt++; if (out_prs1[1] !== 6'd9) $display("FAIL byp_s1_prs1 got %0d want 9", out_prs1[1]); else pass_cnt++;
        total_cnt++; if (out_prs2[1] !== 6'd7) $display("FAIL byp_s1_prs2 got %0d want 7", out_prs2[1]); else pass_cnt++;
        total_cnt++; if (out_prd_old[1] !== 6'd9) $display("FAIL byp_s1_old got %0d want 9", out_prd_old[1]); else pass_cnt++;
        total_cnt++; if (out_prd[1] !== 6'd10) $display("FAIL byp_s1_prd got %0d want 10", out_prd[1]); else pass_cnt++;
        probe(5'd3, 5'd5);
        total_cnt++; if (out_prs1[0] !== 6'd10) $display("FAIL byp_map3 got %0d want 10", out_prs1[0]); else pass_cnt++;
    endtask

    task automatic test_x0_dest();
        clear_in();
        slot(0, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 6'd20);
        slot(1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 6'd21);
        #1;
        total_cnt++; if (prf_req !== 2'b00) $display("FAIL x0_req got %b want 00", prf_req); else pass_cnt++;
        total_cnt++; if (rename_ready !== 1'b1) $display("FAIL x0_ready got %b want 1", rename_ready); else pass_cnt++;
        tick();
        clear_in();
        total_cnt++; if (out_prd !== '0) $display("FAIL x0_prd got %h want 0", out_prd); else pass_cnt++;
        total_cnt++; if (out_prs1[0] !== 6'd10) $display("FAIL x0_prs1 got %0d want 10", out_prs1[0]); else pass_cnt++;
        probe(5'd5, 5'd3);
        total_cnt++; if (out_prs1[0] !== 6'd7) $display("FAIL x0_map5 got %0d want 7", out_prs1[0]); else pass_cnt++;
        total_cnt++; if (out_prs2[0] !== 6'd10) $display("FAIL x0_map3 got %0d want 10", out_prs2[0]); else pass_cnt++;
    endtask

    task automatic test_ckpt_full();
        logic [1:0] exp0 [4];
        logic [1:0] exp1 [4];
        exp0 = '{2'd0, 2'd0, 2'd2, 2'd2};
        exp1 = '{2'd0, 2'd1, 2'd2, 2'd3};
        for (int k = 0; k < 4; k++) begin
            clear_in();
            slot(0, 5'd0, 5'd0, 5'd0, 1'b0, (k % 2) == 0, 6'd0);
            slot(1, 5'd0, 5'd0, 5'd0, 1'b0, (k % 2) == 1, 6'd0);
            tick();
            total_cnt++; if (out_ckpt[0] !== exp0[k]) $display("FAIL full_ckpt0_%0d got %0d want %0d", k, out_ckpt[0], exp0[k]); else pass_cnt++;
            total_cnt++; if (out_ckpt[1] !== exp1[k]) $display("FAIL full_ckpt1_%0d got %0d want %0d", k, out_ckpt[1], exp1[k]); else pass_cnt++;
        end
        clear_in();
        slot(0, 5'd5, 5'd0, 5'd6, 1'b1, 1'b1, 6'd30);
        #1;
        total_cnt++; if (rename_ready !== 1'b0) $display("FAIL full_ready got %b want 0", rename_ready); else pass_cnt++;
        total_cnt++; if (prf_req !== 2'b00) $display("FAIL full_req got %b want 00", prf_req); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 2'b00) $display("FAIL full_valid got %b want 00", out_valid); else pass_cnt++;
        ckpt_release = 1'b1;
        #1;
        total_cnt++; if (rename_ready !== 1'b0) $display("FAIL rel_cycle_ready got %b want 0", rename_ready); else pass_cnt++;
        tick();
        ckpt_release = 1'b0;
        #1;
        total_cnt++; if (rename_ready !== 1'b1) $display("FAIL after_rel_ready got %b want 1", rename_ready); else pass_cnt++;
        total_cnt++; if (prf_req !== 2'b01) $display("FAIL after_rel_req got %b want 01", prf_req); else pass_cnt++;
        tick();
        clear_in();
        total_cnt++; if (out_valid !== 2'b01) $display("FAIL after_rel_valid got %b want 01", out_valid); else pass_cnt++;
        total_cnt++; if (out_ckpt[0] !== 2'd0) $display("FAIL after_rel_ckpt got %0d want 0", out_ckpt[0]); else pass_cnt++;
        total_cnt++; if (out_prd[0] !== 6'd30) $display("FAIL after_rel_prd got %0d want 30", out_prd[0]); else pass_cnt++;
    endtask

    task automatic test_recover();
        clear_in();
        slot(0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 6'd12);
        tick();
        probe(5'd5, 5'd6);
        total_cnt++; if (out_prs1[0] !== 6'd12) $display("FAIL rec_pre_map5 got %0d want 12", out_prs1[0]); else pass_cnt++;
        total_cnt++; if (out_prs2[0] !== 6'd30) $display("FAIL rec_pre_map6 got %0d want 30", out_prs2[0]); else pass_cnt++;
        // Checkpoint 2 was taken with x5=p7 and before x6 was renamed.
        slot(0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 6'd40);
        recover      = 1'b1;
        recover_ckpt = 2'd2;
        #1;
        total_cnt++; if (rename_ready !== 1'b0) $display("FAIL rec_ready got %b want 0", rename_ready); else pass_cnt++;
        total_cnt++; if (prf_req !== 2'b00) $display("FAIL rec_req got %b want 00", prf_req); else pass_cnt++;
        tick();
        clear_in();
        total_cnt++; if (out_valid !== 2'b00) $display("FAIL rec_valid got %b want 00", out_valid); else pass_cnt++;
        probe(5'd5, 5'd6);
        total_cnt++; if (out_prs1[0] !== 6'd7) $display("FAIL rec_map5 got %0d want 7", out_prs1[0]); else pass_cnt++;
        total_cnt++; if (out_prs2[0] !== 6'd0) $display("FAIL rec_map6 got %0d want 0", out_prs2[0]); else pass_cnt++;
        total_cnt++; if (out_ckpt[0] !== 2'd2) $display("FAIL rec_tail_m1 got %0d want 2", out_ckpt[0]); else pass_cnt++;
        probe(5'd7, 5'd3);
        total_cnt++; if (out_prs1[0] !== 6'd0) $display("FAIL rec_map7 got %0d want 0", out_prs1[0]); else pass_cnt++;
        slot(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 6'd0);
        #1;
        total_cnt++; if (rename_ready !== 1'b1) $display("FAIL rec_branch_ready got %b want 1", rename_ready); else pass_cnt++;
        tick();
        clear_in();
        total_cnt++; if (out_ckpt[0] !== 2'd3) $display("FAIL rec_branch_ckpt got %0d want 3", out_ckpt[0]); else pass_cnt++;
    endtask

    task automatic test_stall();
        clear_in();
        slot(0, 5'd5, 5'd0, 5'd8, 1'b1, 1'b0, 6'd50);
        tick();
        clear_in();
        stall = 1'b1;
        slot(0, 5'd3, 5'd0, 5'd9, 1'b1, 1'b0, 6'd51);
        slot(1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 6'd52);
        #1;
        total_cnt++; if (rename_ready !== 1'b0) $display("FAIL stall_ready got %b want 0", rename_ready); else pass_cnt++;
        total_cnt++; if (prf_req !== 2'b11) $display("FAIL stall_req got %b want 11", prf_req); else pass_cnt++;
        tick();
        tick();
        total_cnt++; if (out_valid !== 2'b01) $display("FAIL stall_valid got %b want 01", out_valid); else pass_cnt++;
        total_cnt++; if (out_prd[0] !== 6'd50) $display("FAIL stall_prd got %0d want 50", out_prd[0]); else pass_cnt++;
        total_cnt++; if (out_prs1[0] !== 6'd7) $display("FAIL stall_prs1 got %0d want 7", out_prs1[0]); else pass_cnt++;
        total_cnt++; if (out_prd[1] !== 6'd0) $display("FAIL stall_prd1 got %0d want 0", out_prd[1]); else pass_cnt++;
        probe(5'd9, 5'd10);
        total_cnt++; if (out_prs1[0] !== 6'd0) $display("FAIL stall_map9 got %0d want 0", out_prs1[0]); else pass_cnt++;
        total_cnt++; if (out_prs2[0] !== 6'd0) $display("FAIL stall_map10 got %0d want 0", out_prs2[0]); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        clear_in();
        slot(0, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 6'd33);
        tick();
        clear_in();
        slot(0, 5'd12, 5'd8, 5'd12, 1'b1, 1'b0, 6'd34);
        tick();
        clear_in();
        total_cnt++; if (out_prs1[0] !== 6'd33) $display("FAIL b2b_prs1 got %0d want 33", out_prs1[0]); else pass_cnt++;
        total_cnt++; if (out_prs2[0] !== 6'd50) $display("FAIL b2b_prs2 got %0d want 50", out_prs2[0]); else pass_cnt++;
        total_cnt++; if (out_prd_old[0] !== 6'd33) $display("FAIL b2b_old got %0d want 33", out_prd_old[0]); else pass_cnt++;
        total_cnt++; if (out_prd[0] !== 6'd34) $display("FAIL b2b_prd got %0d want 34", out_prd[0]); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        clear_in();
        slot(0, 5'd8, 5'd0, 5'd11, 1'b1, 1'b0, 6'd60);
        tick();
        total_cnt++; if (out_prd[0] !== 6'd60) $display("FAIL ar_pre_prd got %0d want 60", out_prd[0]); else pass_cnt++;
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 2'b00) $display("FAIL ar_valid got %b want 00", out_valid); else pass_cnt++;
        total_cnt++; if (out_prd[0] !== 6'd0) $display("FAIL ar_prd got %0d want 0", out_prd[0]); else pass_cnt++;
        total_cnt++; if (out_prs1[0] !== 6'd0) $display("FAIL ar_prs1 got %0d want 0", out_prs1[0]); else pass_cnt++;
        clear_in();
        #1;
        reset_n = 1'b1;
        tick();
        probe(5'd8, 5'd11);
        total_cnt++; if (out_prs1[0] !== 6'd0) $display("FAIL ar_map8 got %0d want 0", out_prs1[0]); else pass_cnt++;
        total_cnt++; if (out_prs2[0] !== 6'd0) $display("FAIL ar_map11 got %0d want 0", out_prs2[0]); else pass_cnt++;
        total_cnt++; if (out_ckpt[0] !== 2'd3) $display("FAIL ar_tail_m1 got %0d want 3", out_ckpt[0]); else pass_cnt++;
        slot(0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 6'd0);
        tick();
        clear_in();
        total_cnt++; if (out_ckpt[0] !== 2'd0) $display("FAIL ar_branch_ckpt got %0d want 0", out_ckpt[0]); else pass_cnt++;
    endtask

    initial begin
        reset_n = 1'b0;
        clear_in();
        test_reset();
        test_one_slot();
        test_bypass();
        test_x0_dest();
        test_ckpt_full();
        test_recover();
        test_stall();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
